// File: rtl/pacman_position_controller.sv
`default_nettype none
// ============================================================================
// Module      : pacman_position_controller
// Description : Steps Pacman's tile position at a fixed movement rate using
//               the one-hot player direction. Between steps it probes the
//               maze wall ROM around the current tile. It then publishes the
//               per-direction legal-move flags back to the input controller.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   enable         in   game running; low freezes movement
//   curr_direction in   one-hot direction 1000=L 0100=R 0010=U 0001=D
//   wall_rd_en     out  wall ROM read strobe
//   wall_x/wall_y  out  wall ROM tile address
//   wall_data      in   ROM result (1 = wall), valid the cycle after strobe
//   pos_x/pos_y    out  current tile
//   legal_moves    out  {leg_l, leg_r, leg_u, leg_d}
//   leg_l..leg_d   out  individual copies of the legal_moves bits
//   moved          out  one-cycle pulse when the position changes
// ============================================================================
module pacman_position_controller #(
  parameter int GRID_W   = 28,
  parameter int GRID_H   = 31,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int MOVE_DIV = 1000000,
  parameter int START_X  = 13,
  parameter int START_Y  = 23
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [3:0]     curr_direction,
  output logic           wall_rd_en,
  output logic [X_W-1:0] wall_x,
  output logic [Y_W-1:0] wall_y,
  input  logic           wall_data,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [3:0]     legal_moves,
  output logic           leg_l,
  output logic           leg_r,
  output logic           leg_u,
  output logic           leg_d,
  output logic           moved
);

  localparam int               CNT_W     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_ONE     = X_W'(1);
  localparam logic [Y_W-1:0]   Y_ONE     = Y_W'(1);
  localparam logic [X_W-1:0]   X_START   = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y_START   = Y_W'(START_Y);
  localparam logic [1:0]       IDX_L     = 2'd0;
  localparam logic [1:0]       IDX_R     = 2'd1;
  localparam logic [1:0]       IDX_U     = 2'd2;
  localparam logic [1:0]       IDX_D     = 2'd3;

  typedef enum logic [1:0] {
    S_PROBE   = 2'd0,
    S_CAPTURE = 2'd1,
    S_WAIT    = 2'd2,
    S_MOVE    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic             probe_en;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             stage_l;
  logic             stage_r;
  logic             stage_u;
  logic [X_W-1:0]   x_left;
  logic [X_W-1:0]   x_right;
  logic [Y_W-1:0]   y_up;
  logic [Y_W-1:0]   y_down;
  logic             step_ok;
  logic [X_W-1:0]   x_new;
  logic [Y_W-1:0]   y_new;

  // Neighbour tiles: x wraps through the side tunnel, y clamps at the edges.
  always_comb begin
    x_left  = (pos_x == '0)    ? X_MAX : pos_x - X_ONE;
    x_right = (pos_x == X_MAX) ? '0    : pos_x + X_ONE;
    y_up    = (pos_y == '0)    ? pos_y : pos_y - Y_ONE;
    y_down  = (pos_y == Y_MAX) ? pos_y : pos_y + Y_ONE;
  end

  // Movement rate divider; freezes while the game is paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CNT_ONE;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_PROBE;
      idx   <= IDX_L;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    probe_en  = 1'b0;
    wall_x    = pos_x;
    wall_y    = pos_y;
    case (state)
      S_PROBE: begin
        probe_en = 1'b1;
        case (idx)
          IDX_L:   wall_x = x_left;
          IDX_R:   wall_x = x_right;
          IDX_U:   wall_y = y_up;
          default: wall_y = y_down;
        endcase
        if (idx == IDX_D) begin
          state_nxt = S_CAPTURE;
          idx_nxt   = IDX_L;
        end else begin
          idx_nxt = idx + 2'd1;
        end
      end
      S_CAPTURE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (tick && enable) begin
          state_nxt = S_MOVE;
        end
      end
      S_MOVE:  state_nxt = S_PROBE;
      default: state_nxt = S_PROBE;
    endcase
  end

  // The state register sits in S_PROBE while reset is held, so the strobe is
  // qualified by rst_n to keep the ROM idle during reset.
  assign wall_rd_en = probe_en & rst_n;

  // ROM data arrives one cycle late: probe index k carries the result of k-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_l <= 1'b0;
      stage_r <= 1'b0;
      stage_u <= 1'b0;
    end else if (state == S_PROBE) begin
      case (idx)
        IDX_R:   stage_l <= wall_data;
        IDX_U:   stage_r <= wall_data;
        IDX_D:   stage_u <= wall_data;
        default: ;
      endcase
    end
  end

  // All four flags publish together; the down result is taken straight off
  // the ROM. Up/down are never legal off the top/bottom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      legal_moves <= 4'b0000;
    end else if (state == S_CAPTURE) begin
      legal_moves <= {~stage_l,
                      ~stage_r,
                      ~stage_u   & (pos_y != '0),
                      ~wall_data & (pos_y != Y_MAX)};
    end
  end

  assign leg_l = legal_moves[3];
  assign leg_r = legal_moves[2];
  assign leg_u = legal_moves[1];
  assign leg_d = legal_moves[0];

  // Only an exact one-hot request whose flag is set produces a step.
  always_comb begin
    step_ok = 1'b0;
    x_new   = pos_x;
    y_new   = pos_y;
    case (curr_direction)
      4'b1000: begin step_ok = legal_moves[3]; x_new = x_left;  end
      4'b0100: begin step_ok = legal_moves[2]; x_new = x_right; end
      4'b0010: begin step_ok = legal_moves[1]; y_new = y_up;    end
      4'b0001: begin step_ok = legal_moves[0]; y_new = y_down;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x <= X_START;
      pos_y <= Y_START;
      moved <= 1'b0;
    end else begin
      moved <= 1'b0;
      if ((state == S_MOVE) && step_ok) begin
        pos_x <= x_new;
        pos_y <= y_new;
        moved <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pacman_position_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pacman_position_controller
// Description : Directed bench for pacman_position_controller with a wall ROM
//               model and an expected-position scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_position_controller;

  localparam int GRID_W   = 28;
  localparam int GRID_H   = 31;
  localparam int X_W      = 5;
  localparam int Y_W      = 5;
  localparam int MOVE_DIV = 16;
  localparam int START_X  = 13;
  localparam int START_Y  = 23;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [3:0]     curr_direction = 4'b0000;
  logic           wall_rd_en;
  logic [X_W-1:0] wall_x;
  logic [Y_W-1:0] wall_y;
  logic           wall_data = 1'b0;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic [3:0]     legal_moves;
  logic           leg_l, leg_r, leg_u, leg_d;
  logic           moved;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           mv;
  } exp_t;

  exp_t              sb_q[$];
  logic [GRID_W-1:0] wall_map [GRID_H];
  int                checks = 0;
  int                errors = 0;
  int                now_cyc = 0;
  int                mx = START_X;
  int                my = START_Y;
  int                target;
  logic              seen;

  pacman_position_controller #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W),
    .MOVE_DIV(MOVE_DIV), .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .curr_direction(curr_direction),
    .wall_rd_en(wall_rd_en), .wall_x(wall_x), .wall_y(wall_y), .wall_data(wall_data),
    .pos_x(pos_x), .pos_y(pos_y), .legal_moves(legal_moves),
    .leg_l(leg_l), .leg_r(leg_r), .leg_u(leg_u), .leg_d(leg_d), .moved(moved)
  );

  always #5 clk = ~clk;

  // Wall ROM: one-cycle read latency, out-of-range reads return open.
  always @(posedge clk) begin
    wall_data <= (wall_rd_en && (wall_x < GRID_W) && (wall_y < GRID_H))
                 ? wall_map[wall_y][wall_x] : 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lx(input int x);
    return (x == 0) ? GRID_W - 1 : x - 1;
  endfunction

  function automatic int rx(input int x);
    return (x == GRID_W - 1) ? 0 : x + 1;
  endfunction

  function automatic logic [3:0] model_legal(input int x, input int y);
    logic l, r, u, d;
    l = ~wall_map[y][lx(x)];
    r = ~wall_map[y][rx(x)];
    u = (y != 0) ? ~wall_map[y-1][x] : 1'b0;
    d = (y != GRID_H - 1) ? ~wall_map[y+1][x] : 1'b0;
    return {l, r, u, d};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    now_cyc += n;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos_x"}, pos_x, START_X);
    check({tag, "_pos_y"}, pos_y, START_Y);
    check({tag, "_legal"}, legal_moves, 4'b0000);
    check({tag, "_moved"}, moved, 1'b0);
    check({tag, "_rd_en"}, wall_rd_en, 1'b0);
  endtask

  // Release reset just after a rising edge so negedge n samples cycle n.
  task automatic release_and_probe();
    @(posedge clk);
    #2 rst_n = 1'b1;
    now_cyc = 0;
    wait_cyc(1);
    check("probe_l_rd", wall_rd_en, 1'b1);
    check("probe_l_x", wall_x, lx(mx));
    check("probe_l_y", wall_y, my);
    wait_cyc(1);
    check("probe_r_rd", wall_rd_en, 1'b1);
    check("probe_r_x", wall_x, rx(mx));
    check("probe_r_y", wall_y, my);
    wait_cyc(1);
    check("probe_u_x", wall_x, mx);
    check("probe_u_y", wall_y, my - 1);
    wait_cyc(1);
    check("probe_d_rd", wall_rd_en, 1'b1);
    check("probe_d_x", wall_x, mx);
    check("probe_d_y", wall_y, my + 1);
    wait_cyc(1);
    check("capture_rd", wall_rd_en, 1'b0);
    check("capture_legal_held", legal_moves, 4'b0000);
    wait_cyc(1);
    check("first_legal", legal_moves, model_legal(mx, my));
  endtask

  // One movement period: predict, push, then compare at the update cycle.
  task automatic step(input logic [3:0] dir);
    exp_t       e;
    logic [3:0] lg;
    int         ox, oy, tgt;
    logic       go;
    curr_direction = dir;
    lg = model_legal(mx, my);
    ox = mx;
    oy = my;
    go = 1'b0;
    case (dir)
      4'b1000: if (lg[3]) begin go = 1'b1; mx = lx(mx); end
      4'b0100: if (lg[2]) begin go = 1'b1; mx = rx(mx); end
      4'b0010: if (lg[1]) begin go = 1'b1; my = my - 1; end
      4'b0001: if (lg[0]) begin go = 1'b1; my = my + 1; end
      default: ;
    endcase
    e.x  = mx[X_W-1:0];
    e.y  = my[Y_W-1:0];
    e.mv = go;
    sb_q.push_back(e);
    tgt = ((now_cyc - 2) / MOVE_DIV + 1) * MOVE_DIV + 2;
    wait_cyc(tgt - 1 - now_cyc);
    check("pre_pos_x", pos_x, ox);
    check("pre_pos_y", pos_y, oy);
    check("pre_moved", moved, 1'b0);
    wait_cyc(1);
    e = sb_q.pop_front();
    check("pos_x", pos_x, e.x);
    check("pos_y", pos_y, e.y);
    check("moved", moved, e.mv);
    check("reprobe_rd", wall_rd_en, 1'b1);
    check("reprobe_l_x", wall_x, lx(mx));
    check("reprobe_l_y", wall_y, my);
    wait_cyc(1);
    check("moved_one_cycle", moved, 1'b0);
    wait_cyc(4);
    check("legal", legal_moves, model_legal(mx, my));
    check("leg_bits", {leg_l, leg_r, leg_u, leg_d}, model_legal(mx, my));
  endtask

  initial begin
    for (int y = 0; y < GRID_H; y++) wall_map[y] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    enable = 1'b1;
    release_and_probe();

    // Wall west of the start tile blocks a left request.
    wall_map[START_Y][START_X-1] = 1'b1;
    step(4'b0000);
    step(4'b1000);
    wall_map[START_Y][START_X-1] = 1'b0;

    // Right twice, then left to the tunnel column and up to row 14.
    step(4'b0100);
    step(4'b0100);
    repeat (15) step(4'b1000);
    repeat (9) step(4'b0010);
    step(4'b1000);
    check("tunnel_x", pos_x, 27);

    // Top edge: up is never legal; multi-hot is ignored.
    repeat (14) step(4'b0010);
    check("top_row", pos_y, 0);
    check("top_leg_u", leg_u, 1'b0);
    step(4'b0010);
    step(4'b1100);

    // Reset asserted during probe index 2.
    curr_direction = 4'b0000;
    target = ((now_cyc - 2) / MOVE_DIV + 1) * MOVE_DIV + 2;
    wait_cyc(target + 2 - now_cyc);
    rst_n = 1'b0;
    #1;
    check_reset_values("midprobe_reset");
    repeat (2) @(negedge clk);
    mx = START_X;
    my = START_Y;
    release_and_probe();

    // Bottom edge: down is never legal.
    repeat (7) step(4'b0001);
    check("bottom_leg_d", leg_d, 1'b0);
    step(4'b0001);

    // Pause freezes movement; resuming moves within one period.
    curr_direction = 4'b0010;
    enable = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (moved) seen = 1'b1;
    end
    check("paused_no_move", seen, 1'b0);
    check("paused_pos_y", pos_y, GRID_H - 1);
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < MOVE_DIV + 4 && !seen; i++) begin
      @(negedge clk);
      if (moved) seen = 1'b1;
    end
    check("resume_moved", seen, 1'b1);
    check("resume_pos_y", pos_y, GRID_H - 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pacman_position_controller.md
Name: pacman_position_controller

Overview:
- Consumer side of the player direction interface.
- Takes the registered one-hot direction from the button input controller and steps Pacman's tile position on the maze grid at a fixed movement rate.
- Probes the maze wall ROM around the current tile and drives the per-direction legal-move flags back to the input controller.
- Sits between input handling and the sprite/collision logic.

Parameters:
- GRID_W, 28, maze width in tiles
- GRID_H, 31, maze height in tiles
- X_W, 5, width of the x coordinate
- Y_W, 5, width of the y coordinate
- MOVE_DIV, 1000000, clock cycles per movement step; must be >= 8
- START_X, 13, reset x tile
- START_Y, 23, reset y tile

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  game running; low freezes movement
- curr_direction  in  4  one-hot direction: 1000=L, 0100=R, 0010=U, 0001=D
- wall_rd_en  out  1  wall ROM read strobe
- wall_x  out  X_W  wall ROM x address
- wall_y  out  Y_W  wall ROM y address
- wall_data  in  1  ROM result, valid the cycle after wall_rd_en; 1 = wall
- pos_x  out  X_W  current tile x
- pos_y  out  Y_W  current tile y
- legal_moves  out  4  {leg_l, leg_r, leg_u, leg_d}
- leg_l, leg_r, leg_u, leg_d  out  1  individual legal flags, identical to legal_moves bits
- moved  out  1  one-cycle pulse when the position changes

Behaviour:
- Reset (asynchronous, rst_n low):
  - pos = (START_X, START_Y); legal_moves = 0000; moved = 0; wall_rd_en = 0; tick counter = 0; FSM = S_PROBE with probe index 0.
- Tick counter:
  - Free-running modulo MOVE_DIV while enable = 1; holds its value while enable = 0.
  - tick asserts for one cycle when the counter equals MOVE_DIV-1.
- FSM states: S_PROBE, S_CAPTURE, S_WAIT, S_MOVE.
- S_PROBE (4 cycles, index 0..3 = L, R, U, D):
  - wall_rd_en = 1; addresses are L = (x-1, y), R = (x+1, y), U = (x, y-1), D = (x, y+1).
  - x wraps: x = 0 going L addresses GRID_W-1; x = GRID_W-1 going R addresses 0 (tunnel).
  - y does not wrap: at y = 0 the U address is (x, 0); at y = GRID_H-1 the D address is (x, GRID_H-1).
  - wall_data is captured into a staging register one cycle after each strobe.
  - After index 3, go to S_CAPTURE.
- S_CAPTURE (1 cycle):
  - Capture the D result. wall_rd_en = 0.
  - At the end of this cycle, all four flags update together: flag = ~wall.
  - leg_u is forced to 0 at y = 0; leg_d is forced to 0 at y = GRID_H-1.
  - Go to S_WAIT.
  - A full probe is 5 cycles; legal_moves never shows a partial update.
- S_WAIT: on tick with enable = 1, go to S_MOVE. Otherwise stay.
- S_MOVE (1 cycle):
  - Sample curr_direction. If it is exactly one-hot and the matching flag is 1, update pos (x wraps as in the probe) and pulse moved = 1 in the cycle after S_MOVE.
  - Otherwise pos is unchanged and moved = 0.
  - Non-one-hot values, including 0000, mean no move.
  - Always go to S_PROBE, including when no move occurs.
- Timing:
  - Step period is exactly MOVE_DIV cycles.
  - Because MOVE_DIV >= 8, the probe always completes before the next tick, so no tick is lost.
  - legal_moves for a new tile is valid 5 cycles after the pos update.
- enable dropping mid-probe: the probe still completes; only the move is suppressed.
- Reset mid-probe: all state returns to reset values and probing restarts at index 0 after release. Stale staging data is never published.

Test Plan:
- Reset with rst_n low, then release, with the ROM all-open -> pos = (13, 23), legal_moves = 0000 during reset; wall_rd_en high for 4 cycles with addresses (12,23), (14,23), (13,22), (13,24); legal_moves = 1111 at cycle 5.
- ROM wall only at (12,23), direction 1000 -> legal_moves = 0111; at tick, pos stays (13,23) and moved stays 0.
- ROM all-open, direction 0100, MOVE_DIV = 16 -> pos_x steps 13, 14, 15 on successive ticks 16 cycles apart, with one moved pulse per step.
- pos = (0, 14), tunnel open, direction 1000 -> probe L address is (27, 14); at tick pos becomes (27, 14).
- pos y = 0, ROM all-open -> leg_u = 0; direction 0010 produces no move. Direction 1100 produces no move and moved = 0.
- Assert rst_n low during probe index 2 -> outputs return to reset values immediately; after release, the probe restarts at the L address.
